// File: rtl/traffic_pkg.sv
// Shared lamp/phase encodings and the phase-to-lamp decode for the intersection scheduler.
package traffic_pkg;

    localparam int unsigned LAMP_W  = 2;
    localparam int unsigned PHASE_W = 3;

    typedef enum logic [LAMP_W-1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b11
    } light_t;

    typedef enum logic [PHASE_W-1:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        AR_AB    = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        AR_BA    = 3'd5
    } phase_t;

    typedef struct packed {
        light_t la;
        light_t lb;
    } lamps_t;

    // Unused codes decode to the reset lamps so the outputs stay safe.
    function automatic lamps_t lamp_decode(input phase_t ph);
        lamps_t l;
        case (ph)
            A_GREEN:  l = '{la: GREEN,  lb: RED};
            A_YELLOW: l = '{la: YELLOW, lb: RED};
            B_GREEN:  l = '{la: RED,    lb: GREEN};
            B_YELLOW: l = '{la: RED,    lb: YELLOW};
            AR_AB,
            AR_BA:    l = '{la: RED,    lb: RED};
            default:  l = '{la: GREEN,  lb: RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/parade inputs and lamp/status outputs of the phase scheduler.
interface traffic_phase_scheduler_if;
    import traffic_pkg::*;

    logic                      tick_en;
    logic                      ta;
    logic                      tb;
    logic                      p;
    logic                      r;
    logic [LAMP_W-1:0]         la;
    logic [LAMP_W-1:0]         lb;
    logic                      parade;
    logic [PHASE_W-1:0]        phase;

    modport master (
        output tick_en, ta, tb, p, r,
        input  la, lb, parade, phase
    );

    modport slave (
        input  tick_en, ta, tb, p, r,
        output la, lb, parade, phase
    );

endinterface

// File: rtl/phase_dwell_timer.sv
// Counts ticks spent in the current phase; clears on phase change, saturates at all-ones.
module phase_dwell_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             mode_rstn,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge mode_rstn) begin
        if (!mode_rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-street phase sequencer with min/max green, yellow, all-red clearance and parade hold.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned MIN_GREEN = 8,
    parameter int unsigned MAX_GREEN = 32,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic                      clk,
    input  logic                      mode_rstn,
    traffic_phase_scheduler_if.slave  bus
);

    phase_t             phase;
    phase_t             next_phase;
    light_t             la;
    light_t             lb;
    logic               parade;
    logic               adv;
    logic [CNT_W-1:0]   cnt;
    logic               min_ok;
    logic               max_hit;
    logic               ylw_done;
    logic               ar_done;
    lamps_t             next_lamps;

    phase_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk       (clk),
        .mode_rstn (mode_rstn),
        .clr       (adv),
        .en        (bus.tick_en),
        .cnt       (cnt)
    );

    // Next-phase decision; only a tick can move the sequence.
    always_comb begin
        next_phase = phase;
        min_ok     = cnt >= CNT_W'(MIN_GREEN - 1);
        max_hit    = cnt >= CNT_W'(MAX_GREEN - 1);
        ylw_done   = cnt == CNT_W'(YELLOW_T - 1);
        ar_done    = cnt == CNT_W'(ALLRED_T - 1);
        if (bus.tick_en) begin
            case (phase)
                A_GREEN:  if (min_ok && (parade || (bus.tb && (!bus.ta || max_hit))))
                              next_phase = A_YELLOW;
                A_YELLOW: if (ylw_done) next_phase = AR_AB;
                AR_AB:    if (ar_done)  next_phase = B_GREEN;
                B_GREEN:  if (!parade && min_ok && (!bus.tb || (bus.ta && max_hit)))
                              next_phase = B_YELLOW;
                B_YELLOW: if (ylw_done) next_phase = AR_BA;
                AR_BA:    if (ar_done)  next_phase = A_GREEN;
                default:  next_phase = A_GREEN;
            endcase
        end
        adv        = next_phase != phase;
        next_lamps = lamp_decode(next_phase);
    end

    // Lamps are registered alongside the phase so they track it without decode glitches.
    always_ff @(posedge clk or negedge mode_rstn) begin
        if (!mode_rstn) begin
            phase <= A_GREEN;
            la    <= GREEN;
            lb    <= RED;
        end else begin
            phase <= next_phase;
            la    <= next_lamps.la;
            lb    <= next_lamps.lb;
        end
    end

    // Parade latch runs every clock; release has priority over request.
    always_ff @(posedge clk or negedge mode_rstn) begin
        if (!mode_rstn) begin
            parade <= 1'b0;
        end else if (bus.r) begin
            parade <= 1'b0;
        end else if (bus.p) begin
            parade <= 1'b1;
        end
    end

    assign bus.la     = la;
    assign bus.lb     = lb;
    assign bus.parade = parade;
    assign bus.phase  = phase;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: reference model pushes expected outputs, a monitor pops and compares.
module tb_traffic_phase_scheduler;

    localparam int CNT_MAX = 63;
    localparam int MIN_G   = 4;
    localparam int MAX_G   = 8;
    localparam int YEL     = 2;
    localparam int ALLRED  = 1;

    typedef struct packed {
        logic [1:0] la;
        logic [1:0] lb;
        logic       par;
        logic [2:0] ph;
    } exp_t;

    logic clk = 1'b0;
    logic mode_rstn;
    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .CNT_W(6), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL), .ALLRED_T(ALLRED)
    ) dut (
        .clk       (clk),
        .mode_rstn (mode_rstn),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference state: phase index in the six-step cycle, ticks dwelt, parade flag.
    int   m_ph  = 0;
    int   m_cnt = 0;
    bit   m_par = 1'b0;
    logic [1:0] la_tab [6] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [1:0] lb_tab [6] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    int   fixed_dwell [6]  = '{0, YEL, ALLRED, 0, YEL, ALLRED};

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.la  = la_tab[m_ph];
        e.lb  = lb_tab[m_ph];
        e.par = m_par;
        e.ph  = 3'(m_ph);
        return e;
    endfunction

    function automatic void model_reset();
        m_ph = 0; m_cnt = 0; m_par = 1'b0;
    endfunction

    // One clock of intersection rules, evaluated with ticks counted including the current one.
    function automatic void model_clock();
        bit go;
        int elapsed;
        if (!mode_rstn) begin
            model_reset();
            return;
        end
        if (bus.tick_en) begin
            elapsed = m_cnt + 1;
            if (m_ph == 0)
                go = elapsed >= MIN_G && (m_par || (bus.tb && (!bus.ta || elapsed >= MAX_G)));
            else if (m_ph == 3)
                go = !m_par && elapsed >= MIN_G && (!bus.tb || (bus.ta && elapsed >= MAX_G));
            else
                go = elapsed == fixed_dwell[m_ph];
            if (go) begin
                m_ph  = (m_ph + 1) % 6;
                m_cnt = 0;
            end else if (m_cnt < CNT_MAX) begin
                m_cnt++;
            end
        end
        if (bus.r)      m_par = 1'b0;
        else if (bus.p) m_par = 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        model_clock();
        q.push_back(model_out());
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_in(input bit a, input bit b, input bit pp, input bit rr, input bit te);
        bus.ta = a; bus.tb = b; bus.p = pp; bus.r = rr; bus.tick_en = te;
    endtask

    // Asynchronous reset between clock edges, checked immediately, then released.
    task automatic do_reset(input string name);
        #3;
        mode_rstn = 1'b0;
        model_reset();
        #1;
        chk({name, "_async"}, {bus.la, bus.lb, bus.parade, bus.phase}, {2'b00, 2'b11, 1'b0, 3'd0});
        step();
        step();
        mode_rstn = 1'b1;
    endtask

    // Monitor: every clock the DUT presents lamps/status; compare with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("outputs", 8'({bus.la, bus.lb, bus.parade, bus.phase}),
                    8'({e.la, e.lb, e.par, e.ph}));
                chk("one_street", 8'(bus.la == 2'b11 || bus.lb == 2'b11), 8'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        mode_rstn = 1'b0;
        set_in(0, 0, 0, 0, 1);
        model_reset();
        step();
        step();
        mode_rstn = 1'b1;

        // 1: idle keeps A green
        steps(100);

        // 2: side-street demand only
        do_reset("t2");
        set_in(0, 1, 0, 0, 1);
        steps(30);

        // 3: both streets busy, max-green alternation
        set_in(1, 1, 0, 0, 1);
        steps(50);

        // 4: parade forces and holds B green
        do_reset("t4");
        set_in(1, 0, 0, 0, 1);
        step();
        bus.p = 1'b1; step(); bus.p = 1'b0;
        steps(60);
        bus.r = 1'b1; step(); bus.r = 1'b0;
        steps(20);

        // 5: tick freeze in B green, simultaneous p/r
        do_reset("t5");
        set_in(0, 1, 0, 0, 1);
        steps(10);
        bus.tick_en = 1'b0;
        steps(20);
        bus.p = 1'b1; bus.r = 1'b1; step();
        bus.p = 1'b0; bus.r = 1'b0; bus.tick_en = 1'b1;
        steps(5);

        // 6: reset during B yellow
        bus.tb = 1'b0;
        guard = 0;
        while (m_ph != 4 && guard < 100) begin step(); guard++; end
        chk("reach_b_yellow", 8'(m_ph == 4), 8'd1);
        do_reset("t6");
        set_in(1, 1, 0, 0, 1);
        steps(30);

        // Randomized traffic, time base and parade requests
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) bus.ta = ~bus.ta;
            if ($urandom_range(9) == 0) bus.tb = ~bus.tb;
            bus.tick_en = ($urandom_range(4) != 0);
            bus.p = ($urandom_range(39) == 0);
            bus.r = ($urandom_range(39) == 0);
            step();
        end

        #6;
        chk("drain", 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
